rom_uart_sequencer: RTL
=======================

Name: rom_uart_sequencer

Overview:
Sequencer that walks the 64-entry text/banner ROM from address 0 to LAST_ADDR. It fetches each byte through the ROM's 1-cycle registered read port and hands it to the UART transmitter over a valid/ready handshake. It replays the full message a programmable number of times per start command, then pulses done. It sits between the top-level control (button/command logic) and the UART TX block and owns the ROM address bus.

Parameters:
ADDR_W, 6, ROM address width
DATA_W, 8, ROM/UART byte width
LAST_ADDR, 63, final ROM address of one pass (wrap point)
REP_W, 4, width of the pass-count input

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
start  in  1  request to transmit; sampled only in IDLE
rep_cnt  in  REP_W  number of passes; latched on accepted start; 0 treated as 1
rom_addr  out  ADDR_W  address to ROM, registered
rom_q  in  DATA_W  ROM registered data, valid one cycle after rom_addr is presented
tx_data  out  DATA_W  byte to UART TX, registered
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts byte when tx_valid & tx_ready at posedge
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last byte of the last pass is accepted

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, rom_addr=0, tx_data=0, tx_valid=0, done=0, pass counter=0. Applies from any state; mid-transfer reset drops tx_valid the next cycle without completing the handshake.
- States: IDLE, FETCH, LOAD, SEND, DONE.
- IDLE: rom_addr=0, busy=0. start=1 -> FETCH; pass counter <= (rep_cnt==0 ? 1 : rep_cnt).
- FETCH: rom_addr holds the current address; the ROM samples it at this edge -> LOAD.
- LOAD: rom_q is valid; tx_data <= rom_q, tx_valid <= 1 -> SEND.
- SEND: tx_valid=1, tx_data stable until accepted.
  - On tx_ready=1: tx_valid <= 0.
  - If rom_addr != LAST_ADDR: rom_addr <= rom_addr+1 -> FETCH.
  - Else if pass counter == 1 -> DONE.
  - Else pass counter -1, rom_addr <= 0 -> FETCH.
  - On tx_ready=0: stay in SEND; tx_valid and tx_data are held; no address change.
- DONE: done=1 for exactly one cycle, rom_addr <= 0 -> IDLE. busy=1 in DONE.
- Latency: start sampled at edge N -> FETCH during cycle N+1, LOAD N+2, tx_valid=1 from cycle N+3. With tx_ready tied high, one byte per 3 cycles. A pass of 64 bytes takes 192 cycles; done is asserted the cycle after the final acceptance.
- tx_valid never deasserts without acceptance, except on reset.
- rom_addr changes only on the FETCH-entering transitions (from SEND) and is 0 in IDLE and after DONE.
- Address increment is modulo 2^ADDR_W, but the wrap is controlled by LAST_ADDR, never by overflow. LAST_ADDR < 2^ADDR_W is required.
- start while busy is ignored; it is not queued. start held high continuously restarts one cycle after DONE (IDLE re-samples it).
- rep_cnt changes after acceptance have no effect on the running transfer.
- Simultaneous tx_ready and last byte of the last pass: done follows in the next cycle; no extra byte is sent.

Test Plan:
- Reset then start=1 one cycle, rep_cnt=1, tx_ready=1 -> 64 accepted bytes; first three are 0x20, 0x7C, 0x5C; bytes at addr 14/15 are 0x0D/0x0A; last is 0x0A; done pulses once; busy low afterwards.
- rep_cnt=2, tx_ready=1 -> 128 bytes; byte 64 equals byte 0 (0x20); single done pulse after byte 127.
- rep_cnt=0 -> behaves as one pass: exactly 64 bytes, one done pulse.
- tx_ready low for 10 cycles during byte at addr 3 -> tx_valid stays 1 and tx_data stays 0x5F throughout; rom_addr stays 3; next byte after release is 0x5F (addr 4).
- start pulses at bytes 5 and 40 of an active pass -> ignored; total byte count stays 64 and one done pulse.
- rst_n=0 for one cycle while in SEND at addr 20 -> next cycle tx_valid=0, busy=0, rom_addr=0; a new start begins again at 0x20.

Source files
------------

// File: rtl/rom_uart_sequencer.sv
// Walks the banner ROM from 0 to LAST_ADDR, one registered fetch per byte, and hands each byte to the UART TX.
// Replays the message rep_cnt times (0 counts as 1) per start, then pulses done for one cycle.
module rom_uart_sequencer #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int LAST_ADDR = 63,
  parameter int REP_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [REP_W-1:0]  rep_cnt,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
  localparam logic [REP_W-1:0]  ONE  = REP_W'(1);

  state_t           state;
  logic [REP_W-1:0] pass_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          rom_addr <= '0;
          if (start) begin
            pass_cnt <= (rep_cnt == '0) ? ONE : rep_cnt;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end
        // ROM samples rom_addr on this edge; its data is valid during LOAD.
        FETCH: state <= LOAD;
        LOAD: begin
          tx_data  <= rom_q;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (rom_addr != LAST) begin
              rom_addr <= rom_addr + ADDR_W'(1);
              state    <= FETCH;
            end else if (pass_cnt == ONE) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              pass_cnt <= pass_cnt - ONE;
              rom_addr <= '0;
              state    <= FETCH;
            end
          end
        end
        DONE: begin
          rom_addr <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
